ff_bank: RTL and testbench
==========================

# ff_bank

Parametrised multi-bit flip-flop register bank: WIDTH storage bits whose next state is computed per word in D, T, JK or SR mode, selected at run time. Adds synchronous parallel load, clock enable, per-bit edge pulses, a sticky illegal-SR flag and a saturating change counter. Sits between control logic and downstream consumers wherever the team previously instanced single JK flip-flops, replacing arrays of them with one configurable block.

## Interface
- WIDTH, 8, number of storage bits (1..64)
- RESET_VALUE, 0, value of q after reset (WIDTH bits)
- CNT_W, 8, width of change counter (2..16)

- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- en  input  1  clock enable for mode update
- mode  input  2  00=D, 01=T, 10=JK, 11=SR
- a  input  WIDTH  D: d; T: t; JK: j; SR: s
- b  input  WIDTH  JK: k; SR: r; ignored in D/T
- load  input  1  parallel load strobe
- load_data  input  WIDTH  value loaded when load=1
- clr_err  input  1  clears err_sr
- q  output  WIDTH  stored state
- q_n  output  WIDTH  ~q (combinational from q)
- rise  output  WIDTH  one-cycle pulse, bit went 0->1
- fall  output  WIDTH  one-cycle pulse, bit went 1->0
- err_sr  output  1  sticky: SR mode saw s=r=1 on some bit
- chg_cnt  output  CNT_W  saturating count of cycles in which q changed

## Operation
- Priority per edge: rst_n=0 > load=1 > en=1 > hold.
- Reset: q=RESET_VALUE, rise=0, fall=0, err_sr=0, chg_cnt=0.
- load=1: q<=load_data regardless of en/mode; err_sr not set by this cycle's a/b.
- en=1, load=0, per bit i:
  - D: q[i]<=a[i].
  - T: a[i]=1 toggles, else hold.
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - SR: 00 hold, 01 clear, 10 set, 11 hold that bit and set err_sr.
- en=0, load=0: q holds; a, b, mode ignored.
- rise/fall registered: rise[i]=1 in the cycle after q[i] changed 0->1; fall likewise; both 0 in the cycle after reset.
- chg_cnt increments by 1 on every edge where next q != current q (including load); saturates at 2^CNT_W-1; never wraps.
- err_sr: set by illegal SR; cleared by clr_err; simultaneous set and clr_err -> set wins (stays 1).
- mode may change every cycle; the new mode applies on the same edge.

## Timing
- All outputs except q_n registered; q_n combinational from q.
- Latency: inputs sampled at edge N, q/err_sr/chg_cnt valid after edge N; rise/fall valid after edge N+1 (one cycle later than q).
- Reset asserted mid-sequence: all state returns to reset values on that edge; pending rise/fall pulses are dropped.
- Load on the edge following reset deassertion is honoured.

## Structure
- Package ff_pkg: mode constants MODE_D, MODE_T, MODE_JK, MODE_SR (2-bit localparams / enum).
- Sub-module ff_cell: one-bit combinational next-state (mode, a, b, q -> q_next, illegal). Instanced WIDTH times in a generate loop; ff_bank holds all registers, edge detect, err_sr and counter.

## Test plan
- Reset: WIDTH=8, RESET_VALUE=8'hA5, rst_n=0 one edge -> q=A5, q_n=5A, rise=fall=0, err_sr=0, chg_cnt=0.
- JK sweep from q=00: en=1, a=F0,b=0F -> q=F0; a=FF,b=FF -> q=0F; a=00,b=00 -> q=0F; next cycle after toggle rise=0F, fall=F0.
- SR illegal: q=00, mode=SR, a=03,b=01 -> q=02, err_sr=1; next cycle clr_err=1 with a=b=01 -> err_sr stays 1; clr_err=1 with a=b=0 -> err_sr=0.
- Priority: load=1, load_data=3C, en=1, mode=T, a=FF -> q=3C; en=0, a=FF -> q holds 3C, chg_cnt unchanged.
- Counter saturation: CNT_W=2, T mode a=01 for 5 edges -> chg_cnt 1,2,3,3,3.
- Reset mid-toggle: T mode a=FF running, rst_n=0 one edge -> q=RESET_VALUE, rise=fall=0 next cycle, chg_cnt=0.

Source files
------------

// File: rtl/ff_bank_pkg.sv
// Shared mode encoding for the ff_bank register bank and its per-bit cell.
package ff_pkg;

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

endpackage

// File: rtl/ff_bank_if.sv
// Control/data bundle between a controller (master) and the ff_bank register bank (slave).
interface ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) ();

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             clr_err;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             err_sr;
  logic [CNT_W-1:0] chg_cnt;

  modport master (
    output en, mode, a, b, load, load_data, clr_err,
    input  q, q_n, rise, fall, err_sr, chg_cnt
  );

  modport slave (
    input  en, mode, a, b, load, load_data, clr_err,
    output q, q_n, rise, fall, err_sr, chg_cnt
  );

endinterface

// File: rtl/ff_bank_cell.sv
// One-bit next-state logic for D/T/JK/SR modes; flags s=r=1 in SR mode as illegal.
module ff_cell
  import ff_pkg::*;
(
  input  logic [1:0] i_mode,
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_q,
  output logic       o_qNext,
  output logic       o_illegal
);

  always_comb begin
    o_qNext   = i_q;
    o_illegal = 1'b0;
    case (i_mode)
      MODE_D:  o_qNext = i_a;
      MODE_T:  o_qNext = i_q ^ i_a;
      MODE_JK: begin
        case ({i_a, i_b})
          2'b01:   o_qNext = 1'b0;
          2'b10:   o_qNext = 1'b1;
          2'b11:   o_qNext = ~i_q;
          default: o_qNext = i_q;
        endcase
      end
      MODE_SR: begin
        case ({i_a, i_b})
          2'b01:   o_qNext = 1'b0;
          2'b10:   o_qNext = 1'b1;
          2'b11:   o_illegal = 1'b1;
          default: o_qNext = i_q;
        endcase
      end
      default: o_qNext = i_q;
    endcase
  end

endmodule

// File: rtl/ff_bank.sv
// Configurable flip-flop bank: per-bit mode logic, parallel load, edge pulses,
// sticky illegal-SR flag and a saturating change counter.
module ff_bank
  import ff_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  ff_bank_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qPrev;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_errSr;
  logic [CNT_W-1:0] r_chgCnt;

  logic [WIDTH-1:0] w_qMode;
  logic [WIDTH-1:0] w_illegal;
  logic [WIDTH-1:0] w_qNext;
  logic             w_setErr;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    ff_cell u_cell (
      .i_mode    (bus.mode),
      .i_a       (bus.a[gi]),
      .i_b       (bus.b[gi]),
      .i_q       (r_q[gi]),
      .o_qNext   (w_qMode[gi]),
      .o_illegal (w_illegal[gi])
    );
  end

  always_comb begin
    w_qNext = r_q;
    if (bus.load)
      w_qNext = bus.load_data;
    else if (bus.en)
      w_qNext = w_qMode;
  end

  // A load cycle suppresses the illegal-SR check even when en is high.
  assign w_setErr = bus.en & ~bus.load & (|w_illegal);

  // r_qPrev lags q by one edge so rise/fall appear one cycle after q changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q      <= RESET_VALUE;
      r_qPrev  <= RESET_VALUE;
      r_rise   <= '0;
      r_fall   <= '0;
      r_errSr  <= 1'b0;
      r_chgCnt <= '0;
    end else begin
      r_q     <= w_qNext;
      r_qPrev <= r_q;
      r_rise  <= r_q & ~r_qPrev;
      r_fall  <= ~r_q & r_qPrev;
      if ((w_qNext != r_q) && (r_chgCnt != CNT_MAX))
        r_chgCnt <= r_chgCnt + CNT_ONE;
      if (w_setErr)
        r_errSr <= 1'b1;
      else if (bus.clr_err)
        r_errSr <= 1'b0;
    end
  end

  assign bus.q       = r_q;
  assign bus.q_n     = ~r_q;
  assign bus.rise    = r_rise;
  assign bus.fall    = r_fall;
  assign bus.err_sr  = r_errSr;
  assign bus.chg_cnt = r_chgCnt;

endmodule

// File: tb/tb_ff_bank.sv
// Randomised and directed bench for ff_bank against a behavioural model; a second
// instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_ff_bank;

  localparam logic [7:0] RV = 8'hA5;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [7:0] a;
  logic [7:0] b;
  logic       load;
  logic [7:0] load_data;
  logic       clr_err;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [7:0] mQ;
  logic [7:0] mRise;
  logic [7:0] mFall;
  logic [7:0] pendRise;
  logic [7:0] pendFall;
  logic       mErr;
  int         mCnt;

  ff_bank_if #(.WIDTH(8), .CNT_W(8)) ifc0 ();
  ff_bank_if #(.WIDTH(8), .CNT_W(2)) ifc1 ();

  assign ifc0.en = en;  assign ifc0.mode = mode;  assign ifc0.a = a;  assign ifc0.b = b;
  assign ifc0.load = load;  assign ifc0.load_data = load_data;  assign ifc0.clr_err = clr_err;
  assign ifc1.en = en;  assign ifc1.mode = mode;  assign ifc1.a = a;  assign ifc1.b = b;
  assign ifc1.load = load;  assign ifc1.load_data = load_data;  assign ifc1.clr_err = clr_err;

  ff_bank #(.WIDTH(8), .RESET_VALUE(RV), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
  ff_bank #(.WIDTH(8), .RESET_VALUE(RV), .CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Advance the model by one edge from the current inputs, then let the DUT take the edge.
  task automatic tick();
    logic [7:0] nq;
    logic       ill;
    nq  = mQ;
    ill = 1'b0;
    if (!rst_n) begin
      mQ = RV; mRise = '0; mFall = '0; pendRise = '0; pendFall = '0; mErr = 1'b0; mCnt = 0;
    end else begin
      if (load) nq = load_data;
      else if (en) begin
        for (int i = 0; i < 8; i++) begin
          if (mode == 2'd0) nq[i] = a[i];
          else if (mode == 2'd1) nq[i] = a[i] ? ~mQ[i] : mQ[i];
          else if (mode == 2'd2) begin
            if (a[i] && b[i]) nq[i] = ~mQ[i];
            else if (a[i]) nq[i] = 1'b1;
            else if (b[i]) nq[i] = 1'b0;
          end else begin
            if (a[i] && b[i]) ill = 1'b1;
            else if (a[i]) nq[i] = 1'b1;
            else if (b[i]) nq[i] = 1'b0;
          end
        end
      end
      mRise = pendRise;
      mFall = pendFall;
      pendRise = nq & ~mQ;
      pendFall = ~nq & mQ;
      if (nq != mQ) mCnt++;
      if (ill) mErr = 1'b1;
      else if (clr_err) mErr = 1'b0;
      mQ = nq;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [7:0] av,
                               input logic [7:0] bv, input logic ld, input logic [7:0] ldd,
                               input logic ce);
    en = e; mode = m; a = av; b = bv; load = ld; load_data = ldd; clr_err = ce;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    tick();
    checks++; if (ifc0.q !== 8'hA5) begin errors++; $display("[TB] FAIL reset_q: got %h want %h", ifc0.q, 8'hA5); end
    checks++; if (ifc0.q_n !== 8'h5A) begin errors++; $display("[TB] FAIL reset_qn: got %h want %h", ifc0.q_n, 8'h5A); end
    checks++; if (ifc0.rise !== 8'h00 || ifc0.fall !== 8'h00) begin errors++; $display("[TB] FAIL reset_edges: got rise=%h fall=%h want 00", ifc0.rise, ifc0.fall); end
    checks++; if (ifc0.err_sr !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", ifc0.err_sr); end
    checks++; if (ifc0.chg_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d want 0", ifc0.chg_cnt); end
    rst_n = 1'b1;
  endtask

  task automatic test_jk_sweep();
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0); tick();
    applyStimulus(1'b1, 2'd2, 8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0); tick();
    checks++; if (ifc0.q !== 8'hF0) begin errors++; $display("[TB] FAIL jk_setclr: got %h want %h", ifc0.q, 8'hF0); end
    applyStimulus(1'b1, 2'd2, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0); tick();
    checks++; if (ifc0.q !== 8'h0F) begin errors++; $display("[TB] FAIL jk_toggle: got %h want %h", ifc0.q, 8'h0F); end
    applyStimulus(1'b1, 2'd2, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0); tick();
    checks++; if (ifc0.q !== 8'h0F) begin errors++; $display("[TB] FAIL jk_hold: got %h want %h", ifc0.q, 8'h0F); end
    checks++; if (ifc0.rise !== 8'h0F || ifc0.fall !== 8'hF0) begin errors++; $display("[TB] FAIL jk_edges: got rise=%h fall=%h want 0F/F0", ifc0.rise, ifc0.fall); end
  endtask

  task automatic test_sr_illegal();
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0); tick();
    applyStimulus(1'b1, 2'd3, 8'h03, 8'h01, 1'b0, 8'h00, 1'b0); tick();
    checks++; if (ifc0.q !== 8'h02 || ifc0.err_sr !== 1'b1) begin errors++; $display("[TB] FAIL sr_illegal: got q=%h err=%b want 02/1", ifc0.q, ifc0.err_sr); end
    applyStimulus(1'b1, 2'd3, 8'h01, 8'h01, 1'b0, 8'h00, 1'b1); tick();
    checks++; if (ifc0.err_sr !== 1'b1) begin errors++; $display("[TB] FAIL sr_set_wins: got %b want 1", ifc0.err_sr); end
    applyStimulus(1'b1, 2'd3, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1); tick();
    checks++; if (ifc0.err_sr !== 1'b0 || ifc0.q !== 8'h02) begin errors++; $display("[TB] FAIL sr_clear: got err=%b q=%h want 0/02", ifc0.err_sr, ifc0.q); end
  endtask

  task automatic test_priority();
    logic [7:0] cntSnap;
    applyStimulus(1'b1, 2'd1, 8'hFF, 8'h00, 1'b1, 8'h3C, 1'b0); tick();
    checks++; if (ifc0.q !== 8'h3C) begin errors++; $display("[TB] FAIL prio_load: got %h want %h", ifc0.q, 8'h3C); end
    cntSnap = ifc0.chg_cnt;
    checks++; if (ifc0.chg_cnt !== 8'(sat(mCnt, 255))) begin errors++; $display("[TB] FAIL prio_cnt: got %0d want %0d", ifc0.chg_cnt, sat(mCnt, 255)); end
    applyStimulus(1'b0, 2'd1, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0); tick();
    checks++; if (ifc0.q !== 8'h3C || ifc0.chg_cnt !== cntSnap) begin errors++; $display("[TB] FAIL prio_hold: got q=%h cnt=%0d want 3C/%0d", ifc0.q, ifc0.chg_cnt, cntSnap); end
  endtask

  task automatic test_saturation();
    int expCnt[5] = '{1, 2, 3, 3, 3};
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    applyStimulus(1'b1, 2'd1, 8'h01, 8'h00, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ifc1.chg_cnt !== 2'(expCnt[i]) || int'(ifc1.chg_cnt) != sat(mCnt, 3)) begin
        errors++; $display("[TB] FAIL sat_cnt%0d: got %0d want %0d", i, ifc1.chg_cnt, expCnt[i]);
      end
    end
    checks++; if (ifc0.chg_cnt !== 8'd5) begin errors++; $display("[TB] FAIL wide_cnt: got %0d want 5", ifc0.chg_cnt); end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b1, 2'd1, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    checks++; if (ifc0.rise !== mRise || ifc0.fall !== mFall) begin errors++; $display("[TB] FAIL toggle_edges: got %h/%h want %h/%h", ifc0.rise, ifc0.fall, mRise, mFall); end
    rst_n = 1'b0; tick();
    checks++; if (ifc0.q !== RV || ifc0.chg_cnt !== 8'd0) begin errors++; $display("[TB] FAIL mid_reset: got q=%h cnt=%0d want A5/0", ifc0.q, ifc0.chg_cnt); end
    rst_n = 1'b1;
    applyStimulus(1'b1, 2'd1, 8'hFF, 8'h00, 1'b1, 8'h5A, 1'b0); tick();
    checks++; if (ifc0.q !== 8'h5A) begin errors++; $display("[TB] FAIL load_after_reset: got %h want 5A", ifc0.q); end
    checks++; if (ifc0.rise !== 8'h00 || ifc0.fall !== 8'h00) begin errors++; $display("[TB] FAIL post_reset_edges: got %h/%h want 00/00", ifc0.rise, ifc0.fall); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 29) != 0);
      applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                    ($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 3) == 0));
      tick();
      checks++;
      if (ifc0.q !== mQ || ifc0.q_n !== ~mQ || ifc0.rise !== mRise || ifc0.fall !== mFall ||
          ifc0.err_sr !== mErr || int'(ifc0.chg_cnt) != sat(mCnt, 255) || int'(ifc1.chg_cnt) != sat(mCnt, 3)) begin
        errors++;
        $display("[TB] FAIL rand%0d: got q=%h r=%h f=%h e=%b c=%0d/%0d want q=%h r=%h f=%h e=%b c=%0d/%0d",
                 n, ifc0.q, ifc0.rise, ifc0.fall, ifc0.err_sr, ifc0.chg_cnt, ifc1.chg_cnt,
                 mQ, mRise, mFall, mErr, sat(mCnt, 255), sat(mCnt, 3));
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    mQ = RV; mRise = '0; mFall = '0; pendRise = '0; pendFall = '0; mErr = 1'b0; mCnt = 0;
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    #2;
    test_reset();
    test_jk_sweep();
    test_sr_illegal();
    test_priority();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
